// File: rtl/bresenham_line_drawer.sv
// Integer Bresenham line engine: takes endpoints p and q and emits every pixel
// from p to q, inclusive, over a valid/ready handshake, then pulses done.
module bresenham_line_drawer #(
    parameter int COORD_W = 16,
    parameter int ERR_W   = COORD_W + 3
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [2*COORD_W-1:0]   p,
    input  logic [2*COORD_W-1:0]   q,
    input  logic                   pixel_ready,
    output logic                   pixel_valid,
    output logic [2*COORD_W-1:0]   pixel,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] INIT = 2'd1;
    localparam logic [1:0] STEP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]                state_r;
    logic [1:0]                state_nxt_s;
    logic signed [COORD_W-1:0] cur_x_r, cur_y_r, end_x_r, end_y_r;
    logic signed [ERR_W-1:0]   dx_r, dy_r, err_r;
    logic                      sx_neg_r, sy_neg_r;
    logic                      pixel_valid_r, busy_r, done_r;

    logic signed [ERR_W-1:0]   abs_x_s, abs_y_s, e2_s, add_x_s, add_y_s, err_nxt_s;
    logic signed [COORD_W-1:0] inc_x_s, inc_y_s;
    logic                      step_x_s, step_y_s, handshake_s, at_end_s;

    function automatic logic signed [ERR_W-1:0] sext(input logic [COORD_W-1:0] v);
        return {{(ERR_W-COORD_W){v[COORD_W-1]}}, v};
    endfunction

    function automatic logic signed [ERR_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                         input logic [COORD_W-1:0] b);
        logic signed [ERR_W-1:0] d;
        d = sext(a) - sext(b);
        return d[ERR_W-1] ? -d : d;
    endfunction

    // Step decisions and next error, all from registered state.
    always_comb begin
        abs_x_s     = abs_diff(end_x_r, cur_x_r);
        abs_y_s     = abs_diff(end_y_r, cur_y_r);
        e2_s        = err_r <<< 1;
        step_x_s    = (e2_s >= dy_r);
        step_y_s    = (e2_s <= dx_r);
        handshake_s = pixel_valid_r & pixel_ready;
        at_end_s    = (cur_x_r == end_x_r) && (cur_y_r == end_y_r);
        if (step_x_s) begin
            add_x_s = dy_r;
        end else begin
            add_x_s = {ERR_W{1'b0}};
        end
        if (step_y_s) begin
            add_y_s = dx_r;
        end else begin
            add_y_s = {ERR_W{1'b0}};
        end
        err_nxt_s = err_r + add_x_s + add_y_s;
        if (sx_neg_r) begin
            inc_x_s = {COORD_W{1'b1}};
        end else begin
            inc_x_s = {{(COORD_W-1){1'b0}}, 1'b1};
        end
        if (sy_neg_r) begin
            inc_y_s = {COORD_W{1'b1}};
        end else begin
            inc_y_s = {{(COORD_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state decode for the line FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = INIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            INIT: state_nxt_s = STEP;
            STEP: begin
                if (handshake_s && at_end_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = STEP;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State and registered handshake/status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r       <= IDLE;
            pixel_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pixel_valid_r <= (state_nxt_s == STEP);
            busy_r        <= (state_nxt_s != IDLE);
            done_r        <= (state_nxt_s == DONE);
        end
    end

    // Datapath: cur doubles as the latched start point until INIT derives the deltas.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cur_x_r  <= {COORD_W{1'b0}};
            cur_y_r  <= {COORD_W{1'b0}};
            end_x_r  <= {COORD_W{1'b0}};
            end_y_r  <= {COORD_W{1'b0}};
            dx_r     <= {ERR_W{1'b0}};
            dy_r     <= {ERR_W{1'b0}};
            err_r    <= {ERR_W{1'b0}};
            sx_neg_r <= 1'b0;
            sy_neg_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cur_x_r <= p[2*COORD_W-1:COORD_W];
                        cur_y_r <= p[COORD_W-1:0];
                        end_x_r <= q[2*COORD_W-1:COORD_W];
                        end_y_r <= q[COORD_W-1:0];
                    end
                end
                INIT: begin
                    dx_r     <= abs_x_s;
                    dy_r     <= -abs_y_s;
                    err_r    <= abs_x_s - abs_y_s;
                    sx_neg_r <= !(cur_x_r < end_x_r);
                    sy_neg_r <= !(cur_y_r < end_y_r);
                end
                STEP: begin
                    if (handshake_s && !at_end_s) begin
                        err_r <= err_nxt_s;
                        if (step_x_s) begin
                            cur_x_r <= cur_x_r + inc_x_s;
                        end
                        if (step_y_s) begin
                            cur_y_r <= cur_y_r + inc_y_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pixel_valid = pixel_valid_r;
    assign pixel       = {cur_x_r, cur_y_r};
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: doc/bresenham_line_drawer.md
Name: bresenham_line_drawer

Overview:
Integer Bresenham line engine that acts as the responder on the rasterizer's line-draw interface. It accepts a start pulse with endpoints p and q, then emits every pixel of the line from p to q, inclusive, one per handshake toward the framebuffer writer. When the last pixel is accepted it pulses done, so the controller can advance to the next triangle edge.

Parameters:
COORD_W, 16, width of signed x/y coordinates (matches shortint fields of Point2D)
ERR_W, COORD_W+3, width of signed internal delta/error registers

Ports:
clk  input  1  clock
n_rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request; p/q sampled on this cycle when idle
p  input  Point2D (2xCOORD_W)  line start point {x, y}, signed
q  input  Point2D (2xCOORD_W)  line end point {x, y}, signed
pixel_ready  input  1  framebuffer writer can accept pixel this cycle
pixel_valid  output  1  pixel holds a valid point
pixel  output  Point2D (2xCOORD_W)  current pixel coordinate
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the final pixel is accepted

Behaviour:
- Reset values: state=IDLE; pixel_valid=0, pixel=(0,0), busy=0, done=0; all internal registers 0.
- Reset asserted mid-line: abort immediately to IDLE. No done pulse. Partial line is discarded.
- States: IDLE, INIT, STEP, DONE.
- IDLE: when start=1, latch x0=p.x, y0=p.y, x1=q.x, y1=q.y, then go to INIT. start in any other state is ignored; p/q are not re-sampled.
- INIT (1 cycle), all arithmetic in ERR_W-bit signed, sign-extended from COORD_W:
  - dx=|x1-x0|
  - dy=-|y1-y0|
  - sx=+1 if x0<x1, else -1
  - sy=+1 if y0<y1, else -1
  - err=dx+dy
  - cur=(x0,y0)
  - go to STEP.
- STEP: pixel_valid=1, pixel=cur. Registers advance only on handshake (pixel_valid & pixel_ready). With pixel_ready=0, pixel stays stable.
  - On handshake, if cur==(x1,y1), go to DONE.
  - Otherwise, with e2=2*err computed from the pre-update err:
    - if e2>=dy: err+=dy, cur.x+=sx
    - if e2<=dx: err+=dx, cur.y+=sy
    - Both updates may apply in the same cycle and sum into err.
- DONE (1 cycle): done=1, pixel_valid=0, then go to IDLE. A start arriving in the DONE cycle is ignored; it is accepted in IDLE the following cycle.
- Latency:
  - start sampled at edge N; INIT during cycle N+1; first pixel_valid in cycle N+2.
  - With pixel_ready held high, one pixel per cycle.
  - Pixel count = max(|x1-x0|,|y1-y0|)+1.
  - done asserts in the cycle after the last handshake.
- Degenerate p==q: exactly one pixel, then done.
- Width rules: differences need COORD_W+1 bits, err needs +2, e2 needs +3. ERR_W must not truncate for any COORD_W-bit signed endpoints, including (-32768 -> 32767).
- All octants and pure horizontal/vertical lines are traversed starting at p and ending exactly at q. Output order is p toward q, never reversed.
- pixel_valid never drops in STEP until the final handshake. Outputs are registered or decoded from registered state only; no combinational path from pixel_ready to pixel.

Test Plan:
- Horizontal (0,0)->(3,0), pixel_ready=1: pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles starting 2 cycles after start; done one cycle after (3,0); busy low next cycle.
- Steep (0,0)->(1,3): pixels exactly (0,0),(0,1),(1,2),(1,3), then done pulse of width 1.
- Negative diagonal (5,5)->(2,2) plus negative-x shallow (3,-1)->(-3,1): diagonal gives (5,5),(4,4),(3,3),(2,2); shallow gives 7 pixels, first (3,-1), last (-3,1), monotone x decreasing. Compare against a software Bresenham model.
- Point p==q=(7,7): single pixel (7,7) with valid for one handshake, then done. Also the extreme endpoints (-32768,0)->(32767,0): 65536 pixels, no overflow, last pixel (32767,0).
- Backpressure on (0,0)->(2,1): hold pixel_ready=0 for 3 cycles while (1,0) or (1,1) is presented; pixel stays stable and no pixel is skipped or duplicated. Also pulse start mid-line with different p/q: it is ignored and the line completes unchanged.
- Reset: assert n_rst low during STEP of (0,0)->(10,0) after 4 pixels; outputs go to 0 asynchronously and no done pulse occurs. After release, a new start (2,2)->(2,4) yields (2,2),(2,3),(2,4).
